// File: rtl/memory_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_pkg
// Description : Shared types for the memory stage: memory-op selectors and the
//               execute/write-back Signals bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_stage_pkg;

  typedef enum logic [1:0] {
    MemNone  = 2'd0,
    MemLoad  = 2'd1,
    MemStore = 2'd2
  } MemOp;

  typedef enum logic [1:0] {
    Byte = 2'd0,
    Half = 2'd1,
    Word = 2'd2
  } MemSize;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        branch;
    logic [3:0]  cond;
    logic [3:0]  flags;
    logic        wback;
    logic [4:0]  wreg;
    logic [31:0] wdata;   // ALU result; effective address for memory ops
    MemOp        mem;
    MemSize      size;
    logic        sext;
    logic [31:0] sdata;   // store data
  } Signals;

  // Natural alignment: word on 4 bytes, half on 2, byte anywhere.
  function automatic logic is_aligned(input MemSize size, input logic [1:0] lo);
    case (size)
      Word:    is_aligned = (lo == 2'b00);
      Half:    is_aligned = ~lo[0];
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage_load_align
// Description : Extracts the addressed byte/half from a 32-bit read word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage_load_align
  import memory_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  MemSize      i_size,
  input  logic        i_sext,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection followed by extension according to access size.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      Byte:    o_result = {{24{i_sext & w_byte[7]}}, w_byte};
      Half:    o_result = {{16{i_sext & w_half[15]}}, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : Pipeline stage ahead of write-back. Passes ALU results through
//               in one cycle; performs one load/store per instruction on a
//               registered req/ack data bus, stalling upstream until ack.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  Signals      i_signals,
  output logic        o_busy,
  output logic        o_misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output Signals      o_signals
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  Signals      lat_q, lat_d;
  Signals      out_q, out_d;
  logic        misaligned_q, misaligned_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        w_is_mem;
  logic        w_aligned;
  logic [3:0]  w_store_wstrb;
  logic [31:0] w_store_wdata;
  logic [31:0] w_load_data;

  assign w_is_mem  = i_signals.valid && (i_signals.mem != MemNone);
  assign w_aligned = is_aligned(i_signals.size, i_signals.wdata[1:0]);

  // Load data comes from the latched address/size, not the live input.
  memory_stage_load_align u_load_align (
    .i_rdata   (dmem_rdata),
    .i_addr_lo (lat_q.wdata[1:0]),
    .i_size    (lat_q.size),
    .i_sext    (lat_q.sext),
    .o_result  (w_load_data)
  );

  // Byte enables and lane-replicated store data for the incoming instruction.
  always_comb begin
    w_store_wstrb = 4'b1111;
    w_store_wdata = i_signals.sdata;
    case (i_signals.size)
      Byte: begin
        w_store_wstrb = 4'b0001 << i_signals.wdata[1:0];
        w_store_wdata = {4{i_signals.sdata[7:0]}};
      end
      Half: begin
        w_store_wstrb = 4'b0011 << {i_signals.wdata[1], 1'b0};
        w_store_wdata = {2{i_signals.sdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Next-state: enter WAIT on an aligned memory op, leave on ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_is_mem && w_aligned) state_d = ST_WAIT;
      ST_WAIT: if (dmem_ack)              state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Datapath and bus next values; the bus stays stable while req is high.
  always_comb begin
    lat_d        = lat_q;
    out_d        = out_q;
    misaligned_d = 1'b0;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        out_d = i_signals;
        if (w_is_mem) begin
          if (w_aligned) begin
            lat_d       = i_signals;
            out_d.valid = 1'b0;
            req_d       = 1'b1;
            we_d        = (i_signals.mem == MemStore);
            addr_d      = {i_signals.wdata[31:2], 2'b00};
            wdata_d     = w_store_wdata;
            wstrb_d     = (i_signals.mem == MemStore) ? w_store_wstrb : 4'b0000;
          end else begin
            // Dropped access: no bus cycle, result not written back.
            out_d.wback  = 1'b0;
            misaligned_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        out_d.valid = 1'b0;
        if (dmem_ack) begin
          out_d       = lat_q;
          out_d.valid = 1'b1;
          if (lat_q.mem == MemLoad) out_d.wdata = w_load_data;
          else                      out_d.wback = 1'b0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
        end
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      out_q        <= '0;
      misaligned_q <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      out_q        <= out_d;
      misaligned_q <= misaligned_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  assign o_busy       = (state_q == ST_WAIT);
  assign o_misaligned = misaligned_q;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_wstrb   = wstrb_q;
  assign o_signals    = out_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_stage
// Description : Self-checking bench for memory_stage with a byte-level memory
//               model and directed plus randomized instruction sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  Signals      i_signals, o_signals;
  logic        o_busy, o_misaligned;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          done_cyc = 0;
  logic [31:0] mem_model [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_stage dut (
    .clk          (clk),
    .rst          (rst),
    .i_signals    (i_signals),
    .o_busy       (o_busy),
    .o_misaligned (o_misaligned),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_wstrb   (dmem_wstrb),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .o_signals    (o_signals)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic int nbytes(input MemSize s);
    case (s)
      Byte:    return 1;
      Half:    return 2;
      default: return 4;
    endcase
  endfunction

  // Reference load: shift/mask then two's-complement wrap for sign extension.
  function automatic logic [31:0] exp_load(input logic [31:0] word, input int off,
                                           input int nb, input bit sext);
    longint unsigned v;
    v = ({32'd0, word} >> (8 * off)) % (64'd1 << (8 * nb));
    if (sext && nb < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_wstrb(input int off, input int nb);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = (k >= off) && (k < off + nb);
    return r;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input int nb);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sd[8*(k % nb) +: 8];
    return r;
  endfunction

  function automatic Signals rand_bundle();
    Signals s;
    s.valid  = 1'b1;
    s.pc     = $urandom;
    s.branch = 1'($urandom);
    s.cond   = 4'($urandom);
    s.flags  = 4'($urandom);
    s.wback  = 1'($urandom);
    s.wreg   = 5'($urandom);
    s.wdata  = $urandom;
    s.mem    = MemNone;
    s.size   = MemSize'(2'($urandom_range(0, 2)));
    s.sext   = 1'($urandom);
    s.sdata  = $urandom;
    return s;
  endfunction

  task automatic pass_op(input Signals s);
    i_signals = s;
    step();
    chk("pass_out", {11'd0, o_signals}, {11'd0, s});
    chk("pass_req", dmem_req, 0);
    chk("pass_mis", o_misaligned, 0);
  endtask

  // Present one memory op; the bus slave acks after 'delay' extra wait cycles.
  task automatic mem_op(input Signals s, input int delay);
    int          off, nb, idx, busy_cnt;
    Signals      exp;
    logic [31:0] waddr;
    bit          is_st;
    off      = int'(s.wdata[1:0]);
    nb       = nbytes(s.size);
    idx      = int'(s.wdata[5:2]);
    waddr    = s.wdata - 32'(off);
    is_st    = (s.mem == MemStore);
    busy_cnt = 0;
    i_signals = s;
    step();
    if ((off % nb) != 0) begin
      exp = s;
      exp.wback = 1'b0;
      chk("mis_out", {11'd0, o_signals}, {11'd0, exp});
      chk("mis_flag", o_misaligned, 1);
      chk("mis_req", dmem_req, 0);
      i_signals.valid = 1'b0;
      step();
      chk("mis_pulse", o_misaligned, 0);
      chk("mis_req2", dmem_req, 0);
      return;
    end
    chk("req_we", dmem_we, is_st);
    chk("req_wstrb", dmem_wstrb, is_st ? exp_wstrb(off, nb) : 4'b0000);
    if (is_st) chk("req_wdata", dmem_wdata, exp_wdata(s.sdata, nb));
    chk("req_mis", o_misaligned, 0);
    for (int c = 0; c <= delay; c++) begin
      if (o_busy) busy_cnt++;
      chk("req_hold", {dmem_req, dmem_addr}, {1'b1, waddr});
      chk("wait_valid", o_signals.valid, 0);
      if (c == delay) begin
        dmem_ack   = 1'b1;
        dmem_rdata = is_st ? $urandom : mem_model[idx];
      end
      step();
    end
    dmem_ack   = 1'b0;
    dmem_rdata = $urandom;
    chk("busy_cycles", busy_cnt, delay + 1);
    exp = s;
    exp.valid = 1'b1;
    if (is_st) begin
      exp.wback = 1'b0;
      for (int i = 0; i < nb; i++) mem_model[idx][8*(off+i) +: 8] = s.sdata[8*i +: 8];
    end else begin
      exp.wdata = exp_load(mem_model[idx], off, nb, s.sext);
    end
    chk("mem_out", {11'd0, o_signals}, {11'd0, exp});
    chk("req_drop", dmem_req, 0);
    chk("busy_drop", o_busy, 0);
    done_cyc = cyc;
    i_signals.valid = 1'b0;
  endtask

  initial begin
    Signals s;
    int     first_done;
    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    i_signals  = '0;
    for (int i = 0; i < 16; i++) mem_model[i] = $urandom;

    // Reset state
    step();
    step();
    chk("rst_out", {11'd0, o_signals}, 0);
    chk("rst_bus", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}, 0);
    chk("rst_flags", {o_busy, o_misaligned}, 0);
    rst = 1'b0;

    // ALU pass-through
    s = rand_bundle();
    s.wreg  = 5'd5;
    s.wdata = 32'h1234;
    pass_op(s);
    chk("alu_wdata", o_signals.wdata, 32'h1234);

    // Load byte, sign-extended, ack in the third wait cycle
    mem_model[0] = 32'h80FF_0000;
    s = rand_bundle();
    s.mem = MemLoad; s.size = Byte; s.sext = 1'b1; s.wdata = 32'h1003;
    mem_op(s, 2);
    chk("lb_const", o_signals.wdata, 32'hFFFF_FF80);

    // Store half in the upper lanes
    s = rand_bundle();
    s.mem = MemStore; s.size = Half; s.wdata = 32'h2002; s.sdata = 32'h0000_BEEF;
    mem_op(s, 1);

    // Misaligned word load
    s = rand_bundle();
    s.mem = MemLoad; s.size = Word; s.wdata = 32'h3001;
    mem_op(s, 0);

    // Reset while waiting, followed by a late ack
    s = rand_bundle();
    s.mem = MemLoad; s.size = Word; s.wdata = 32'h1004;
    i_signals = s;
    step();
    chk("rw_req", dmem_req, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    i_signals = '0;
    chk("rw_req_drop", dmem_req, 0);
    chk("rw_out", {11'd0, o_signals}, 0);
    chk("rw_bus", {o_busy, o_misaligned, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}, 0);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("rw_late_ack", {o_signals.valid, dmem_req, o_busy}, 0);

    // Back-to-back word loads with same-cycle ack
    s = rand_bundle();
    s.mem = MemLoad; s.size = Word; s.wdata = 32'h5008;
    mem_op(s, 0);
    first_done = done_cyc;
    s = rand_bundle();
    s.mem = MemLoad; s.size = Word; s.wdata = 32'h600C;
    mem_op(s, 0);
    chk("b2b_spacing", done_cyc - first_done, 2);

    // Randomized mix of pass-through, bubbles and memory ops
    for (int n = 0; n < 80; n++) begin
      s = rand_bundle();
      case ($urandom_range(0, 5))
        0: pass_op(s);
        1: begin
          s.valid = 1'b0;
          s.mem   = MemOp'(2'($urandom_range(0, 2)));
          pass_op(s);
        end
        default: begin
          s.mem   = $urandom_range(0, 1) ? MemLoad : MemStore;
          s.wdata = {26'($urandom), 6'($urandom)};
          mem_op(s, int'($urandom_range(0, 3)));
        end
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
